// File: rtl/ysyx_22051013_regfile_sb_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package ysyx_22051013_regfile_sb_pkg;

    localparam int unsigned RF_XLEN     = 64;
    localparam int unsigned RF_NREG     = 32;
    localparam int unsigned RF_AW       = $clog2(RF_NREG);
    localparam int unsigned RF_ZERO_REG = 0;
    localparam logic        RF_EN       = 1'b1;

endpackage

// File: rtl/ysyx_22051013_regfile_rdport.sv
// One read port: same-cycle write forwarding, register select and busy flag.
module ysyx_22051013_regfile_rdport
    import ysyx_22051013_regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN   = RF_XLEN,
    parameter int unsigned NREG   = RF_NREG,
    parameter int unsigned AW     = RF_AW,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic              i_rst,
    input  logic              i_ren,
    input  logic [AW-1:0]     i_raddr,
    input  logic [XLEN-1:0]   i_regs [NREG],
    input  logic [NREG-1:0]   i_pend,
    input  logic [NWR-1:0]    i_wen,
    input  logic [NWR*AW-1:0] i_waddr,
    input  logic [NWR*XLEN-1:0] i_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_rbusy
);

    logic            w_zero;
    logic            w_hit;
    logic            w_byp;
    logic [XLEN-1:0] w_fwd;

    assign w_zero = (i_raddr == AW'(RF_ZERO_REG));

    // Later ports overwrite earlier matches so the highest index wins.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int k = 0; k < NWR; k++) begin
            if (i_wen[k] == RF_EN && i_waddr[k*AW +: AW] == i_raddr && !w_zero) begin
                w_hit = 1'b1;
                w_fwd = i_wdata[k*XLEN +: XLEN];
            end
        end
    end

    assign w_byp = (BYPASS != 0) && w_hit;

    always_comb begin
        o_rdata = '0;
        o_rbusy = 1'b0;
        if (!i_rst && i_ren == RF_EN && !w_zero) begin
            o_rdata = w_byp ? w_fwd : i_regs[i_raddr];
            o_rbusy = i_pend[i_raddr] & ~w_byp;
        end
    end

endmodule

// File: rtl/ysyx_22051013_regfile_sb.sv
// Multi-port register file with a per-register pending (scoreboard) bit and pending count.
module ysyx_22051013_regfile_sb
    import ysyx_22051013_regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN   = RF_XLEN,
    parameter int unsigned NREG   = RF_NREG,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD-1:0]      ren,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                bset,
    input  logic [AW-1:0]       baddr,
    output logic [AW:0]         bcnt
);

    // r_gpr is the array the difftest harness reaches hierarchically.
    logic [XLEN-1:0] r_gpr [NREG];
    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_d;
    logic [AW:0]     r_bcnt;
    logic [AW:0]     w_bcnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wen[k] == RF_EN && waddr[k*AW +: AW] != AW'(RF_ZERO_REG)) begin
                    r_gpr[waddr[k*AW +: AW]] <= wdata[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Set is applied after clear so a new producer survives a same-cycle writeback.
    always_comb begin
        w_pend_d = r_pend;
        for (int k = 0; k < NWR; k++) begin
            if (wen[k] == RF_EN) begin
                w_pend_d[waddr[k*AW +: AW]] = 1'b0;
            end
        end
        if (bset == RF_EN && baddr != AW'(RF_ZERO_REG)) begin
            w_pend_d[baddr] = 1'b1;
        end
        w_pend_d[RF_ZERO_REG] = 1'b0;
    end

    always_comb begin
        w_bcnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            w_bcnt_d = w_bcnt_d + {{AW{1'b0}}, w_pend_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_bcnt <= '0;
        end else begin
            r_pend <= w_pend_d;
            r_bcnt <= w_bcnt_d;
        end
    end

    assign bcnt = r_bcnt;

    for (genvar g_rd = 0; g_rd < NRD; g_rd++) begin : g_rdport
        ysyx_22051013_regfile_rdport #(
            .XLEN   (XLEN),
            .NREG   (NREG),
            .AW     (AW),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_rdport (
            .i_rst   (rst),
            .i_ren   (ren[g_rd]),
            .i_raddr (raddr[g_rd*AW +: AW]),
            .i_regs  (r_gpr),
            .i_pend  (r_pend),
            .i_wen   (wen),
            .i_waddr (waddr),
            .i_wdata (wdata),
            .o_rdata (rdata[g_rd*XLEN +: XLEN]),
            .o_rbusy (rbusy[g_rd])
        );
    end

endmodule
